// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle of every signal exchanged between the pipeline sequencing
//   controller and the datapath.
//
//   Parameter:
//     STALL_CNT_W  width of the stall-cycle counter
//
//   Datapath -> controller:
//     ihit, dhit                 instruction / data access completes this cycle
//     memcuDRE, memcuDWE         MEM stage holds a load / store
//     memcuHALT                  MEM stage holds a halt
//     exBranchTaken              EX stage resolved a redirect
//     exMemToReg, exwsel         EX stage load flag and destination register
//     idrs, idrt                 ID stage source registers
//   Controller -> datapath:
//     imemREN                    instruction read request
//     pcW, ifidW, idexW, exmemW, memwbW     latch write enables
//     ifidRST, idexRST, exmemRST, memwbRST  latch flushes
//     halt                       sticky halt flag
//     stall_cnt                  saturating count of cycles with pcW=0
//
//   Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   ihit;
  logic                   dhit;
  logic                   memcuDRE;
  logic                   memcuDWE;
  logic                   memcuHALT;
  logic                   exBranchTaken;
  logic                   exMemToReg;
  logic [4:0]             exwsel;
  logic [4:0]             idrs;
  logic [4:0]             idrt;

  logic                   imemREN;
  logic                   pcW;
  logic                   ifidW;
  logic                   idexW;
  logic                   exmemW;
  logic                   memwbW;
  logic                   ifidRST;
  logic                   idexRST;
  logic                   exmemRST;
  logic                   memwbRST;
  logic                   halt;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    input  ihit, dhit, memcuDRE, memcuDWE, memcuHALT, exBranchTaken,
           exMemToReg, exwsel, idrs, idrt,
    output imemREN, pcW, ifidW, idexW, exmemW, memwbW,
           ifidRST, idexRST, exmemRST, memwbRST, halt, stall_cnt
  );

  modport slave (
    output ihit, dhit, memcuDRE, memcuDWE, memcuHALT, exBranchTaken,
           exMemToReg, exwsel, idrs, idrt,
    input  imemREN, pcW, ifidW, idexW, exmemW, memwbW,
           ifidRST, idexRST, exmemRST, memwbRST, halt, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Sequencing controller for the five-stage pipeline. Produces write-enable
//   and flush controls for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB
//   latches, arbitrates the shared memory port (data wins), inserts load-use
//   bubbles, flushes wrong-path instructions on a taken redirect, latches
//   halt and counts stalled cycles (saturating).
//
//   Ports:
//     CLK  clock, rising edge
//     RST  synchronous active-high reset
//     bus  pipeline_ctrl_if.master (all datapath handshake/control signals)
//
//   Optional feature: define LOADUSE_STALL_EN to enable load-use detection
//   and bubbling. Left undefined, a MEM forwarding path is assumed to cover
//   load results and the load-use inputs are ignored.
//
//   All control outputs are combinational from state and current inputs;
//   halt, state and stall_cnt update on the edge ending the deciding cycle.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  pipeline_ctrl_if.master      bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   halt_q, halt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic dreq;
  logic loaduse;

  assign dreq = bus.memcuDRE | bus.memcuDWE;

`ifdef LOADUSE_STALL_EN
  assign loaduse = bus.exMemToReg && (bus.exwsel != 5'd0) &&
                   ((bus.exwsel == bus.idrs) || (bus.exwsel == bus.idrt));
`else
  // Forwarding covers load results; these inputs are intentionally unused.
  logic unused_loaduse_inputs;
  assign unused_loaduse_inputs = ^{bus.exMemToReg, bus.exwsel, bus.idrs, bus.idrt};
  assign loaduse = 1'b0;
`endif

  // Data access always owns the shared port; nothing is fetched once halted.
  assign bus.imemREN   = (state_q != HALTED) && !dreq;
  // Reserved for exception handling; never flushes in this revision.
  assign bus.memwbRST  = 1'b0;
  assign bus.halt      = halt_q;
  assign bus.stall_cnt = stall_cnt_q;

  // Next-state and latch-control decision. The latches give W priority over
  // RST, so every flush below is issued with that latch's W held at 0.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    halt_d       = halt_q;
    bus.pcW      = 1'b0;
    bus.ifidW    = 1'b0;
    bus.idexW    = 1'b0;
    bus.exmemW   = 1'b0;
    bus.memwbW   = 1'b0;
    bus.ifidRST  = 1'b0;
    bus.idexRST  = 1'b0;
    bus.exmemRST = 1'b0;

    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (state_q == RUN && bus.memcuHALT) begin
      state_d = HALTED;
      halt_d  = 1'b1;
    end else if (dreq && !bus.dhit) begin
      state_d = DWAIT;
    end else if (dreq) begin
      // Data access done: retire MEM into WB, bubble EX/MEM, hold front end.
      state_d      = RUN;
      bus.memwbW   = 1'b1;
      bus.exmemRST = 1'b1;
    end else if (!bus.ihit) begin
      state_d      = RUN;
      bus.memwbW   = 1'b1;
      bus.exmemRST = 1'b1;
    end else if (bus.exBranchTaken) begin
      // Redirect: kill the two wrong-path instructions in IF/ID and ID/EX.
      state_d     = RUN;
      bus.pcW     = 1'b1;
      bus.exmemW  = 1'b1;
      bus.memwbW  = 1'b1;
      bus.ifidRST = 1'b1;
      bus.idexRST = 1'b1;
    end else if (loaduse) begin
      // Hold PC and IF/ID, push a bubble into ID/EX behind the load.
      state_d     = RUN;
      bus.exmemW  = 1'b1;
      bus.memwbW  = 1'b1;
      bus.idexRST = 1'b1;
    end else begin
      state_d    = RUN;
      bus.pcW    = 1'b1;
      bus.ifidW  = 1'b1;
      bus.idexW  = 1'b1;
      bus.exmemW = 1'b1;
      bus.memwbW = 1'b1;
    end
  end

  // Stall counter saturates at all-ones and freezes once halted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != HALTED && !bus.pcW && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
